// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 constants, clock-derived timings and state enum
package ws2812_pkg;

  localparam int CLK_FRE      = 27_000_000;
  localparam int WS2812_WIDTH = 24;
  localparam int CLK_PER_US   = CLK_FRE / 1_000_000;

  // Nominal line timings in clocks, shared with the transmitter
  localparam int T0H       = CLK_PER_US * 40 / 100;
  localparam int T0L       = CLK_PER_US * 85 / 100;
  localparam int T1H       = CLK_PER_US * 80 / 100;
  localparam int T1L       = CLK_PER_US * 45 / 100;
  localparam int RESET_LOW = CLK_PER_US * 50;

  localparam int BIT_THRESH = 16;
  localparam int MIN_HIGH   = 3;
  localparam int MAX_HIGH   = 40;

  typedef enum logic [1:0] {
    WAIT_RESET,
    IDLE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/ws2812_pulse_meas.sv
// rtl/ws2812_pulse_meas.sv - din synchroniser, edge detect and saturating level-width counter
module ws2812_pulse_meas
  import ws2812_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic        din_s,
  output logic        rise_strobe,
  output logic        fall_strobe,
  output logic [15:0] width,
  output logic        low_timeout
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_prev;
  logic [15:0] r_cnt;
  logic        w_edge;

  assign w_edge = r_sync2 ^ r_prev;

  // Restart at 1 on an edge so width equals the level length in clocks when the next edge arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_edge)
        r_cnt <= 16'd1;
      else if (r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign din_s       = r_sync2;
  assign rise_strobe = r_sync2 & ~r_prev;
  assign fall_strobe = ~r_sync2 & r_prev;
  assign width       = r_cnt;
  assign low_timeout = ~r_sync2 & ~r_prev & (r_cnt == 16'(RESET_LOW));

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 pixel-style receiver: bit decode, word assembly, frame detect, forwarding
module ws2812_rx
  import ws2812_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  output logic                    dout,
  output logic [WS2812_WIDTH-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    frame_end,
  output logic                    rx_err,
  output logic [7:0]              word_cnt
);

  localparam int BCW = $clog2(WS2812_WIDTH + 1);

  logic                    w_din_s, w_rise, w_fall, w_low_timeout;
  logic [15:0]             w_width;
  state_t                  r_state, w_state_nxt;
  logic [WS2812_WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [WS2812_WIDTH-1:0] r_data, w_data_nxt;
  logic [BCW-1:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]              r_word_cnt, w_word_nxt;
  logic                    r_valid, r_err, r_fe, r_dout;
  logic                    w_valid_nxt, w_err_nxt, w_fe_nxt, w_fwd;

  ws2812_pulse_meas u_meas (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_s       (w_din_s),
    .rise_strobe (w_rise),
    .fall_strobe (w_fall),
    .width       (w_width),
    .low_timeout (w_low_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= WAIT_RESET;
      r_shift    <= '0;
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= 8'd0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_fe       <= 1'b0;
      r_dout     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_word_cnt <= w_word_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_fe       <= w_fe_nxt;
      r_dout     <= w_din_s & w_fwd;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_bit_cnt_nxt = r_bit_cnt;
    w_word_nxt    = r_word_cnt;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    w_fe_nxt      = 1'b0;
    w_shifted     = {r_shift[WS2812_WIDTH-2:0], (w_width > 16'(BIT_THRESH))};
    case (r_state)
      WAIT_RESET: begin
        w_bit_cnt_nxt = '0;
        if (w_low_timeout) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_rise) begin
          w_state_nxt   = HIGH;
          w_bit_cnt_nxt = '0;
          w_word_nxt    = 8'd0;
        end
      end
      HIGH: begin
        if (w_fall) begin
          if (w_width < 16'(MIN_HIGH) || w_width > 16'(MAX_HIGH)) begin
            w_err_nxt     = 1'b1;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = WAIT_RESET;
          end else begin
            w_shift_nxt = w_shifted;
            w_state_nxt = LOW;
            if (r_bit_cnt == BCW'(WS2812_WIDTH - 1)) begin
              w_data_nxt    = w_shifted;
              w_valid_nxt   = 1'b1;
              w_bit_cnt_nxt = '0;
              if (r_word_cnt != 8'hFF) w_word_nxt = r_word_cnt + 8'd1;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
            end
          end
        end else if (w_width > 16'(MAX_HIGH)) begin
          w_err_nxt     = 1'b1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = WAIT_RESET;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
        end else if (w_low_timeout) begin
          w_fe_nxt      = 1'b1;
          w_err_nxt     = (r_bit_cnt != '0);
          w_bit_cnt_nxt = '0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = WAIT_RESET;
    endcase
  end

  // Forward only inside a frame that has already kept its first word
  assign w_fwd = (r_state == HIGH || r_state == LOW) && (r_word_cnt != 8'd0) && !w_fe_nxt;

  assign dout      = r_dout;
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_end = r_fe;
  assign rx_err    = r_err;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - directed self-checking bench for ws2812_rx
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        dout, rx_valid, frame_end, rx_err;
  logic [23:0] rx_data;
  logic [7:0]  word_cnt;

  int errors = 0;
  int checks = 0;

  int cyc = 0, cyc_valid = 0, cyc_fe = 0;
  int n_valid = 0, n_err = 0, n_fe = 0, n_fe_err = 0, n_overlap = 0;
  int n_dout_out = 0, n_dout_in = 0, n_mism = 0;
  int s_valid, s_err, s_fe, s_fe_err, s_dout_out, s_dout_in, s_mism;
  logic       in_w2 = 1'b0;
  logic [2:0] hist = 3'b000;

  always #5 clk = ~clk;

  ws2812_rx dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dout      (dout),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_end (frame_end),
    .rx_err    (rx_err),
    .word_cnt  (word_cnt)
  );

  always @(negedge clk) begin
    cyc  <= cyc + 1;
    hist <= {hist[1:0], din};
    if (rx_valid) begin
      n_valid   <= n_valid + 1;
      cyc_valid <= cyc;
    end
    if (frame_end) begin
      n_fe   <= n_fe + 1;
      cyc_fe <= cyc;
    end
    if (rx_err) n_err <= n_err + 1;
    if (frame_end && rx_err) n_fe_err <= n_fe_err + 1;
    if (rx_valid && (frame_end || rx_err)) n_overlap <= n_overlap + 1;
    if (in_w2) begin
      if (dout) n_dout_in <= n_dout_in + 1;
      if (dout !== hist[2]) n_mism <= n_mism + 1;
    end else if (dout) begin
      n_dout_out <= n_dout_out + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_valid = n_valid; s_err = n_err; s_fe = n_fe; s_fe_err = n_fe_err;
    s_dout_out = n_dout_out; s_dout_in = n_dout_in; s_mism = n_mism;
  endtask

  // Entered and left at 1 time unit after a rising edge; holds din for n edges
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit_h(input logic b, input int hi);
    hold(1'b1, hi);
    hold(1'b0, b ? 11 : 23);
  endtask

  task automatic send_bit(input logic b);
    send_bit_h(b, b ? 23 : 11);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic gap();
    hold(1'b0, 1400);
  endtask

  initial begin
    logic [23:0] pat;
    rst = 1'b1;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {6'd0, dout, rx_valid, frame_end, rx_err, word_cnt, 16'd0}, 32'd0);
    check("reset_rx_data", {8'd0, rx_data}, 32'd0);
    rst = 1'b0;
    gap();

    // 1: single word
    snap();
    send_word(24'h000100);
    gap();
    check("t1_valid_cnt", n_valid - s_valid, 1);
    check("t1_rx_data", {8'd0, rx_data}, 32'h000100);
    check("t1_frame_end_cnt", n_fe - s_fe, 1);
    check("t1_fe_delay", cyc_fe - cyc_valid, 1350);
    check("t1_word_cnt", {24'd0, word_cnt}, 1);
    check("t1_dout_quiet", n_dout_out - s_dout_out, 0);
    check("t1_err_cnt", n_err - s_err, 0);

    // 2: two words, forwarding of word 2 only
    snap();
    send_word(24'h000001);
    in_w2 = 1'b1;
    send_word(24'hABCDEF);
    in_w2 = 1'b0;
    gap();
    check("t2_valid_cnt", n_valid - s_valid, 2);
    check("t2_rx_data", {8'd0, rx_data}, 32'hABCDEF);
    check("t2_word_cnt", {24'd0, word_cnt}, 2);
    check("t2_dout_word1_quiet", n_dout_out - s_dout_out, 0);
    check("t2_dout_follow", n_mism - s_mism, 0);
    check("t2_dout_high_clks", n_dout_in - s_dout_in, 468);
    check("t2_err_cnt", n_err - s_err, 0);

    // 3: bit threshold sweep on the first bit
    for (int hi = 16; hi <= 17; hi++) begin
      snap();
      send_bit_h(1'b0, hi);
      for (int i = 0; i < 23; i++) send_bit(1'b0);
      gap();
      check("t3_valid_cnt", n_valid - s_valid, 1);
      check("t3_rx_data", {8'd0, rx_data}, (hi == 17) ? 32'h800000 : 32'h000000);
    end

    // 4: glitch inside a word, then a clean frame
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    hold(1'b1, 2);
    hold(1'b0, 23);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    gap();
    check("t4_glitch_err", n_err - s_err, 1);
    check("t4_glitch_no_valid", n_valid - s_valid, 0);
    check("t4_glitch_no_fe", n_fe - s_fe, 0);
    snap();
    send_word(24'h123456);
    gap();
    check("t4_valid_cnt", n_valid - s_valid, 1);
    check("t4_rx_data", {8'd0, rx_data}, 32'h123456);

    // 5: truncated word, then overlong high
    snap();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    gap();
    check("t5_trunc_fe", n_fe - s_fe, 1);
    check("t5_trunc_fe_err_same", n_fe_err - s_fe_err, 1);
    check("t5_trunc_err", n_err - s_err, 1);
    check("t5_trunc_no_valid", n_valid - s_valid, 0);
    check("t5_trunc_data_kept", {8'd0, rx_data}, 32'h123456);
    snap();
    hold(1'b1, 60);
    hold(1'b0, 100);
    send_word(24'h0F0F0F);
    gap();
    check("t5_long_err", n_err - s_err, 1);
    check("t5_long_ignored", n_valid - s_valid, 0);
    check("t5_long_no_fe", n_fe - s_fe, 0);
    snap();
    send_word(24'h0F0F0F);
    gap();
    check("t5_recover_valid", n_valid - s_valid, 1);
    check("t5_recover_data", {8'd0, rx_data}, 32'h0F0F0F);

    // 6: reset mid-word
    pat = 24'hAAAAAA;
    for (int i = 23; i >= 12; i--) send_bit(pat[i]);
    rst = 1'b1;
    #1;
    check("t6_rst_outputs", {6'd0, dout, rx_valid, frame_end, rx_err, word_cnt, 16'd0}, 32'd0);
    check("t6_rst_rx_data", {8'd0, rx_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    snap();
    send_word(24'h00FF00);
    gap();
    check("t6_nogap_ignored", n_valid - s_valid, 0);
    check("t6_nogap_no_fe", n_fe - s_fe, 0);
    snap();
    send_word(24'h00FF00);
    gap();
    check("t6_valid_cnt", n_valid - s_valid, 1);
    check("t6_rx_data", {8'd0, rx_data}, 32'h00FF00);
    check("t6_word_cnt", {24'd0, word_cnt}, 1);

    check("valid_never_with_fe_err", n_overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
